// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file plus rename-tag table.
// Issue records the producing ROB tag for a destination register. Commit
// writes the value and releases the tag if it still belongs to the committing
// entry. A flush clears every tag. Operand lookup is combinational and
// resolves pending tags through the ROB ready/value query.
// Optional build macro RF_CMT_BYPASS_EN: forwards a same-cycle commit straight
// to lookup when it releases the tag being read.
module reg_status_file #(
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 4,
  parameter int DAT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush_i,
  input  logic               is_en_i,
  input  logic [REG_BIT-1:0] is_rd_i,
  input  logic [ROB_BIT-1:0] is_q_i,
  input  logic [REG_BIT-1:0] rs1_i,
  input  logic [REG_BIT-1:0] rs2_i,
  output logic [ROB_BIT-1:0] qj_o,
  output logic [ROB_BIT-1:0] qk_o,
  output logic [DAT_W-1:0]   vj_o,
  output logic [DAT_W-1:0]   vk_o,
  output logic [ROB_BIT-1:0] rob_reqqj_o,
  output logic [ROB_BIT-1:0] rob_reqqk_o,
  input  logic               rob_rdyj_i,
  input  logic               rob_rdyk_i,
  input  logic [DAT_W-1:0]   rob_rdyvj_i,
  input  logic [DAT_W-1:0]   rob_rdyvk_i,
  input  logic               cmt_en_i,
  input  logic [REG_BIT-1:0] cmt_rd_i,
  input  logic [ROB_BIT-1:0] cmt_q_i,
  input  logic [DAT_W-1:0]   cmt_v_i
);

  localparam int NREG = 1 << REG_BIT;

  logic [DAT_W-1:0]   val [NREG];
  logic [ROB_BIT-1:0] tag [NREG];

  logic cmt_wr;
  logic is_wr;
  logic byp_j;
  logic byp_k;

  // Writes to x0 are discarded, so x0 keeps value 0 and tag 0 forever.
  assign cmt_wr = cmt_en_i && (cmt_rd_i != '0);
  assign is_wr  = is_en_i && (is_rd_i != '0);

  // State update: reset, then flush (commit value still lands, tags all drop), then normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '{default: '0};
      tag <= '{default: '0};
    end else if (flush_i) begin
      if (cmt_wr) val[cmt_rd_i] <= cmt_v_i;
      tag <= '{default: '0};
    end else if (en) begin
      if (cmt_wr) begin
        val[cmt_rd_i] <= cmt_v_i;
        // A younger producer may already own the register; only release our own tag.
        if (tag[cmt_rd_i] == cmt_q_i) tag[cmt_rd_i] <= '0;
      end
      // Issue after commit so a same-cycle rename of the same register wins.
      if (is_wr) tag[is_rd_i] <= is_q_i;
    end
  end

  // Commit-to-lookup bypass qualifiers.
  always_comb begin
    byp_j = 1'b0;
    byp_k = 1'b0;
`ifdef RF_CMT_BYPASS_EN
    byp_j = cmt_wr && (cmt_rd_i == rs1_i) && (tag[rs1_i] == cmt_q_i);
    byp_k = cmt_wr && (cmt_rd_i == rs2_i) && (tag[rs2_i] == cmt_q_i);
`endif
  end

  // Resolve one operand: architected value, forwarded commit, ROB result, or pending tag.
  function automatic logic [ROB_BIT+DAT_W-1:0] resolve(
    input logic               zero_reg,
    input logic [ROB_BIT-1:0] t,
    input logic [DAT_W-1:0]   v,
    input logic               byp,
    input logic [DAT_W-1:0]   bv,
    input logic               rdy,
    input logic [DAT_W-1:0]   rv
  );
    logic [ROB_BIT-1:0] q;
    logic [DAT_W-1:0]   d;
    q = '0;
    d = '0;
    if (zero_reg) begin
      q = '0;
      d = '0;
    end else if (t == '0) begin
      d = v;
    end else if (byp) begin
      d = bv;
    end else if (rdy) begin
      d = rv;
    end else begin
      q = t;
    end
    return {q, d};
  endfunction

  // Combinational operand lookup for both source registers.
  always_comb begin
    rob_reqqj_o = tag[rs1_i];
    rob_reqqk_o = tag[rs2_i];
    {qj_o, vj_o} = resolve(rs1_i == '0, tag[rs1_i], val[rs1_i], byp_j, cmt_v_i,
                           rob_rdyj_i, rob_rdyvj_i);
    {qk_o, vk_o} = resolve(rs2_i == '0, tag[rs2_i], val[rs2_i], byp_k, cmt_v_i,
                           rob_rdyk_i, rob_rdyvk_i);
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_reg_status_file;

  localparam int REG_BIT = 5;
  localparam int ROB_BIT = 4;
  localparam int DAT_W   = 32;

  logic               clk = 1'b0;
  logic               rst, en, flush_i;
  logic               is_en_i;
  logic [REG_BIT-1:0] is_rd_i;
  logic [ROB_BIT-1:0] is_q_i;
  logic [REG_BIT-1:0] rs1_i, rs2_i;
  logic [ROB_BIT-1:0] qj_o, qk_o, rob_reqqj_o, rob_reqqk_o;
  logic [DAT_W-1:0]   vj_o, vk_o;
  logic               rob_rdyj_i, rob_rdyk_i;
  logic [DAT_W-1:0]   rob_rdyvj_i, rob_rdyvk_i;
  logic               cmt_en_i;
  logic [REG_BIT-1:0] cmt_rd_i;
  logic [ROB_BIT-1:0] cmt_q_i;
  logic [DAT_W-1:0]   cmt_v_i;

  int checks = 0;
  int errors = 0;

  // Reference state: architected value and pending producer per register.
  logic [DAT_W-1:0]   mval [32];
  logic [ROB_BIT-1:0] mtag [32];

  reg_status_file #(.REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT), .DAT_W(DAT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .is_en_i(is_en_i), .is_rd_i(is_rd_i), .is_q_i(is_q_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .qj_o(qj_o), .qk_o(qk_o), .vj_o(vj_o), .vk_o(vk_o),
    .rob_reqqj_o(rob_reqqj_o), .rob_reqqk_o(rob_reqqk_o),
    .rob_rdyj_i(rob_rdyj_i), .rob_rdyk_i(rob_rdyk_i),
    .rob_rdyvj_i(rob_rdyvj_i), .rob_rdyvk_i(rob_rdyvk_i),
    .cmt_en_i(cmt_en_i), .cmt_rd_i(cmt_rd_i), .cmt_q_i(cmt_q_i), .cmt_v_i(cmt_v_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // Register state transition, expressed directly from the architectural rules.
  function automatic void model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mval[i] = '0;
        mtag[i] = '0;
      end
      return;
    end
    if (!flush_i && !en) return;
    if (cmt_en_i && cmt_rd_i != 0) begin
      mval[cmt_rd_i] = cmt_v_i;
      if (!flush_i && mtag[cmt_rd_i] == cmt_q_i) mtag[cmt_rd_i] = '0;
    end
    if (flush_i) begin
      for (int i = 0; i < 32; i++) mtag[i] = '0;
    end else if (is_en_i && is_rd_i != 0) begin
      mtag[is_rd_i] = is_q_i;
    end
  endfunction

  function automatic void ref_lookup(input logic [REG_BIT-1:0] r, input logic rdy,
                                     input logic [DAT_W-1:0] rv,
                                     output logic [ROB_BIT-1:0] q,
                                     output logic [DAT_W-1:0] v,
                                     output logic [ROB_BIT-1:0] req);
    logic byp;
    req = mtag[r];
    q = '0;
    v = '0;
    byp = 1'b0;
`ifdef RF_CMT_BYPASS_EN
    byp = cmt_en_i && cmt_rd_i == r && mtag[r] == cmt_q_i;
`endif
    if (r == 0) begin
      q = '0;
      v = '0;
    end else if (mtag[r] == 0) v = mval[r];
    else if (byp) v = cmt_v_i;
    else if (rdy) v = rv;
    else q = mtag[r];
  endfunction

  task automatic check_lookup(input string nm);
    logic [ROB_BIT-1:0] eq, ereq;
    logic [DAT_W-1:0]   ev;
    #1;
    ref_lookup(rs1_i, rob_rdyj_i, rob_rdyvj_i, eq, ev, ereq);
    chk({nm, ".qj"}, 32'(qj_o), 32'(eq));
    chk({nm, ".vj"}, vj_o, ev);
    chk({nm, ".reqj"}, 32'(rob_reqqj_o), 32'(ereq));
    ref_lookup(rs2_i, rob_rdyk_i, rob_rdyvk_i, eq, ev, ereq);
    chk({nm, ".qk"}, 32'(qk_o), 32'(eq));
    chk({nm, ".vk"}, vk_o, ev);
    chk({nm, ".reqk"}, 32'(rob_reqqk_o), 32'(ereq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    rst = 0; en = 1; flush_i = 0;
    is_en_i = 0; is_rd_i = '0; is_q_i = '0;
    cmt_en_i = 0; cmt_rd_i = '0; cmt_q_i = '0; cmt_v_i = '0;
    rob_rdyj_i = 0; rob_rdyk_i = 0; rob_rdyvj_i = '0; rob_rdyvk_i = '0;
    rs1_i = '0; rs2_i = '0;
  endtask

  initial begin
    quiet();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '1;
      mtag[i] = '1;
    end
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    rs1_i = 5; rs2_i = 0;
    check_lookup("reset");
    chk("reset_qj", 32'(qj_o), 0);
    chk("reset_vj", vj_o, 0);

    // Rename x5 to tag 3, then resolve through the ROB query
    is_en_i = 1; is_rd_i = 5; is_q_i = 3;
    tick();
    quiet();
    rs1_i = 5;
    check_lookup("pend5");
    chk("pend5_qj", 32'(qj_o), 3);
    chk("pend5_req", 32'(rob_reqqj_o), 3);
    rob_rdyj_i = 1; rob_rdyvj_i = 32'h1234;
    check_lookup("rdy5");
    chk("rdy5_qj", 32'(qj_o), 0);
    chk("rdy5_vj", vj_o, 32'h1234);

    // Older commit must not release a younger producer's tag
    quiet(); is_en_i = 1; is_rd_i = 7; is_q_i = 2; tick();
    is_q_i = 4; tick();
    quiet(); cmt_en_i = 1; cmt_rd_i = 7; cmt_q_i = 2; cmt_v_i = 32'hAA; tick();
    quiet(); rs1_i = 7;
    check_lookup("old_cmt7");
    chk("old_cmt7_qj", 32'(qj_o), 4);
    cmt_en_i = 1; cmt_rd_i = 7; cmt_q_i = 4; cmt_v_i = 32'hBB; tick();
    quiet(); rs1_i = 7;
    check_lookup("cmt7");
    chk("cmt7_vj", vj_o, 32'hBB);

    // Same-cycle issue and commit to one register: issue wins the tag
    is_en_i = 1; is_rd_i = 9; is_q_i = 5; tick();
    quiet(); is_en_i = 1; is_rd_i = 9; is_q_i = 6;
    cmt_en_i = 1; cmt_rd_i = 9; cmt_q_i = 5; cmt_v_i = 32'h55; tick();
    quiet(); rs1_i = 9;
    check_lookup("iss_cmt9");
    chk("iss_cmt9_qj", 32'(qj_o), 6);

    // Flush: commit value lands, all tags drop, issue ignored
    is_en_i = 1; is_rd_i = 3; is_q_i = 1; tick();
    is_rd_i = 4; is_q_i = 2; tick();
    quiet(); flush_i = 1;
    cmt_en_i = 1; cmt_rd_i = 1; cmt_q_i = 1; cmt_v_i = 32'h80;
    is_en_i = 1; is_rd_i = 8; is_q_i = 3; tick();
    quiet(); rs1_i = 1; rs2_i = 3;
    check_lookup("flush_a");
    chk("flush_vj1", vj_o, 32'h80);
    chk("flush_qk3", 32'(qk_o), 0);
    rs1_i = 8; rs2_i = 4;
    check_lookup("flush_b");
    chk("flush_qj8", 32'(qj_o), 0);
    chk("flush_qk4", 32'(qk_o), 0);

    // x0 ignores writes and renames
    is_en_i = 1; is_rd_i = 0; is_q_i = 5;
    cmt_en_i = 1; cmt_rd_i = 0; cmt_q_i = 5; cmt_v_i = 32'hFF; tick();
    quiet(); rs1_i = 0; rob_rdyj_i = 1; rob_rdyvj_i = 32'hDEAD;
    check_lookup("x0");
    chk("x0_qj", 32'(qj_o), 0);
    chk("x0_vj", vj_o, 0);

    // Stall holds state
    quiet(); en = 0; is_en_i = 1; is_rd_i = 10; is_q_i = 7;
    cmt_en_i = 1; cmt_rd_i = 7; cmt_q_i = 0; cmt_v_i = 32'h77; tick();
    quiet(); rs1_i = 10; rs2_i = 7;
    check_lookup("stall");
    chk("stall_qj", 32'(qj_o), 0);
    chk("stall_vk", vk_o, 32'hBB);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      quiet();
      rst     = ($urandom_range(0, 299) == 0);
      en      = ($urandom_range(0, 7) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      is_en_i = $urandom_range(0, 1);
      is_rd_i = REG_BIT'($urandom_range(0, 31));
      is_q_i  = ROB_BIT'($urandom_range(1, 15));
      cmt_en_i = $urandom_range(0, 1);
      cmt_rd_i = REG_BIT'($urandom_range(0, 31));
      cmt_q_i  = ROB_BIT'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1 && mtag[cmt_rd_i] != 0) cmt_q_i = mtag[cmt_rd_i];
      cmt_v_i = $urandom;
      rs1_i = ($urandom_range(0, 3) == 0) ? cmt_rd_i : REG_BIT'($urandom_range(0, 31));
      rs2_i = ($urandom_range(0, 3) == 0) ? is_rd_i : REG_BIT'($urandom_range(0, 31));
      rob_rdyj_i = $urandom_range(0, 1);
      rob_rdyk_i = $urandom_range(0, 1);
      rob_rdyvj_i = $urandom;
      rob_rdyvk_i = $urandom;
      if (!rst) check_lookup("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus rename-tag table for the out-of-order core.
- Sits directly downstream of the reorder buffer's commit port and upstream of the reservation stations and LSB operand capture.
- On issue, it records which ROB entry will produce each destination register.
- On commit, it writes the architected value and releases the tag; on mispredict flush, it drops all tags.
- Operand lookup is combinational and resolves a pending tag through the ROB's ready/value query.

Parameters:
- REG_BIT, 5, register index width (32 registers).
- ROB_BIT, 4, ROB tag width; tag 0 is never allocated and means "no pending producer".
- DAT_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global stall enable; low holds all state except flush/reset
- flush_i  in  1  ROB mispredict flag (br_flag), one-cycle pulse
- is_en_i  in  1  instruction issued this cycle with a destination write
- is_rd_i  in  REG_BIT  destination register of issued instruction
- is_q_i  in  ROB_BIT  ROB tail tag assigned to that instruction
- rs1_i  in  REG_BIT  source register 1 of instruction being decoded
- rs2_i  in  REG_BIT  source register 2
- qj_o  out  ROB_BIT  pending tag for rs1, 0 if value valid
- qk_o  out  ROB_BIT  pending tag for rs2
- vj_o  out  DAT_W  value for rs1 (valid when qj_o==0)
- vk_o  out  DAT_W  value for rs2
- rob_reqqj_o  out  ROB_BIT  tag of rs1 sent to ROB ready query
- rob_reqqk_o  out  ROB_BIT  tag of rs2 sent to ROB ready query
- rob_rdyj_i  in  1  ROB entry rob_reqqj_o has its result
- rob_rdyk_i  in  1  ROB entry rob_reqqk_o has its result
- rob_rdyvj_i  in  DAT_W  that result
- rob_rdyvk_i  in  DAT_W  that result
- cmt_en_i  in  1  ROB commit write (rf_en_o)
- cmt_rd_i  in  REG_BIT  committed destination
- cmt_q_i  in  ROB_BIT  committed ROB tag
- cmt_v_i  in  DAT_W  committed value

Behaviour:
- State: val[32] (DAT_W), tag[32] (ROB_BIT). All updates on posedge clk.
- Reset (rst=1): all val and tag cleared to 0. Outputs are combinational from state, so qj_o/qk_o/vj_o/vk_o read 0 and rob_reqq*_o read 0 after reset.
- Priority: rst > flush_i > en. flush_i and rst act regardless of en.
- Commit (cmt_en_i & cmt_rd_i!=0):
  - val[cmt_rd_i] <= cmt_v_i.
  - tag[cmt_rd_i] <= 0 only if tag[cmt_rd_i]==cmt_q_i; otherwise a younger producer owns it and the tag is kept.
- Issue (is_en_i & is_rd_i!=0): tag[is_rd_i] <= is_q_i.
- Same-cycle issue and commit to the same rd: the value is written and the tag becomes is_q_i (issue wins).
- Flush cycle:
  - Commit value write is still performed, because the ROB raises rf_en_o together with br_flag on JALR.
  - Every tag is cleared to 0.
  - Issue is ignored.
- en=0 without flush: commit and issue are ignored and state holds.
- x0: writes and renames to register 0 are discarded. Lookup of x0 always returns q=0, v=0.
- Lookup (combinational, zero latency), rs1 path; rs2 identical with k signals:
  - rob_reqqj_o = tag[rs1_i].
  - If tag==0: qj_o=0, vj_o=val[rs1_i].
  - Else if rob_rdyj_i: qj_o=0, vj_o=rob_rdyvj_i.
  - Else: qj_o=tag, vj_o=0.
- Lookup observes pre-edge state; same-cycle issue/commit effects are visible next cycle unless the optional feature is on.

Optional Feature:
- Macro RF_CMT_BYPASS_EN.
- Defined: if cmt_en_i and cmt_rd_i==rs1_i (!=0) and tag[rs1_i]==cmt_q_i, lookup returns qj_o=0, vj_o=cmt_v_i in the commit cycle (same for rs2), without waiting for the ROB query.
- Undefined: no bypass. The ROB ready query alone covers this case, since the ROB entry stays ready until overwritten.

Test Plan:
- Reset, then rs1=5, rs2=0 -> qj=0, vj=0, qk=0, vk=0.
- Issue rd=5 q=3. Next cycle rs1=5 with rob_rdyj=0 -> qj=3, rob_reqqj=3. With rob_rdyj=1 and rob_rdyvj=0x1234 -> qj=0, vj=0x1234.
- Issue rd=7 q=2, then rd=7 q=4, then commit rd=7 q=2 v=0xAA -> val[7]=0xAA, tag[7] stays 4. Then commit q=4 v=0xBB -> tag 0, vj=0xBB.
- Same cycle: issue rd=9 q=6 and commit rd=9 q=5 v=0x55 (tag was 5) -> val[9]=0x55, tag[9]=6.
- Tags on x3=1, x4=2. Assert flush_i with cmt_en rd=1 q=1 v=0x80 and is_en rd=8 q=3 -> all tags 0, val[1]=0x80, x8 not renamed.
- Issue rd=0 q=5 and commit rd=0 v=0xFF -> rs1=0 reads q=0, v=0.
